// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sequencer for a push-button decimal calculator.
// Collects two decimal operands digit by digit, latches an operator,
// launches an external ALU and holds the returned result for display.
// Optional build macro: CALC_SEQ_EDGE_EN - when defined, set and append are
// rising-edge qualified so a held button acts only once.
module calc_seq_ctrl #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        append,
  input  logic [9:0]  key,
  input  logic        add,
  input  logic        sub,
  input  logic        mul,
  input  logic        div,
  input  logic        alu_done,
  input  logic [27:0] alu_result,
  output logic [13:0] operand_a,
  output logic [13:0] operand_b,
  output logic [1:0]  op_code,
  output logic        alu_start,
  output logic [27:0] result,
  output logic        result_valid,
  output logic [2:0]  state,
  output logic [2:0]  digit_cnt,
  output logic        key_err,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTER_A  = 3'd1,
    ENTER_OP = 3'd2,
    ENTER_B  = 3'd3,
    CALC     = 3'd4,
    SHOW     = 3'd5
  } state_t;

  state_t      state_q;
  logic [13:0] operand_a_q, operand_b_q;
  logic [1:0]  op_code_q;
  logic        alu_start_q;
  logic [27:0] result_q;
  logic        result_valid_q;
  logic [2:0]  digit_cnt_q;
  logic        key_err_q;
  logic        div_zero_q;

  logic        set_p_d, append_p_d;
  logic        key_ok_d, op_ok_d, digit_room_d;
  logic [3:0]  digit_d;
  logic [1:0]  op_sel_d;
  logic [13:0] acc_a_d, acc_b_d;

  // True when exactly one bit of the digit keypad is pressed.
  function automatic logic onehot10(input logic [9:0] k);
    return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
  endfunction

  // Decimal value of a one-hot key vector (highest set bit wins).
  function automatic logic [3:0] key_digit(input logic [9:0] k);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

`ifdef CALC_SEQ_EDGE_EN
  logic set_prev_q, append_prev_q;

  // One-cycle delayed copies of the buttons for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_prev_q    <= 1'b0;
      append_prev_q <= 1'b0;
    end else begin
      set_prev_q    <= set;
      append_prev_q <= append;
    end
  end

  assign set_p_d    = set & ~set_prev_q;
  assign append_p_d = append & ~append_prev_q;
`else
  assign set_p_d    = set;
  assign append_p_d = append;
`endif

  // Input decode: key validity, digit value, operator select and accumulators.
  always_comb begin
    key_ok_d     = onehot10(key);
    digit_d      = key_digit(key);
    digit_room_d = (digit_cnt_q < 3'(MAX_DIGITS));
    acc_a_d      = (operand_a_q * 14'd10) + {10'd0, digit_d};
    acc_b_d      = (operand_b_q * 14'd10) + {10'd0, digit_d};
    op_ok_d      = (({3'd0, add} + {3'd0, sub} + {3'd0, mul} + {3'd0, div}) == 4'd1);
    if (div) begin
      op_sel_d = 2'd3;
    end else if (mul) begin
      op_sel_d = 2'd2;
    end else if (sub) begin
      op_sel_d = 2'd1;
    end else begin
      op_sel_d = 2'd0;
    end
  end

  // Main sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      operand_a_q    <= 14'd0;
      operand_b_q    <= 14'd0;
      op_code_q      <= 2'd0;
      alu_start_q    <= 1'b0;
      result_q       <= 28'd0;
      result_valid_q <= 1'b0;
      digit_cnt_q    <= 3'd0;
      key_err_q      <= 1'b0;
      div_zero_q     <= 1'b0;
    end else begin
      alu_start_q <= 1'b0;
      key_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (set_p_d) begin
            state_q        <= ENTER_A;
            operand_a_q    <= 14'd0;
            operand_b_q    <= 14'd0;
            digit_cnt_q    <= 3'd0;
            result_valid_q <= 1'b0;
            div_zero_q     <= 1'b0;
          end
        end
        ENTER_A: begin
          if (set_p_d) begin
            state_q     <= ENTER_OP;
            digit_cnt_q <= 3'd0;
          end else if (append_p_d) begin
            if (key_ok_d && digit_room_d) begin
              operand_a_q <= acc_a_d;
              digit_cnt_q <= digit_cnt_q + 3'd1;
            end else begin
              key_err_q <= 1'b1;
            end
          end
        end
        ENTER_OP: begin
          if (set_p_d) begin
            if (op_ok_d) begin
              op_code_q <= op_sel_d;
              state_q   <= ENTER_B;
            end else begin
              key_err_q <= 1'b1;
            end
          end
        end
        ENTER_B: begin
          if (set_p_d) begin
            state_q     <= CALC;
            digit_cnt_q <= 3'd0;
            // Division by zero is resolved here so the ALU is never launched.
            if ((op_code_q == 2'd3) && (operand_b_q == 14'd0)) begin
              div_zero_q <= 1'b1;
              result_q   <= 28'd0;
            end else begin
              alu_start_q <= 1'b1;
            end
          end else if (append_p_d) begin
            if (key_ok_d && digit_room_d) begin
              operand_b_q <= acc_b_d;
              digit_cnt_q <= digit_cnt_q + 3'd1;
            end else begin
              key_err_q <= 1'b1;
            end
          end
        end
        CALC: begin
          if (div_zero_q) begin
            state_q <= SHOW;
          end else if (alu_done) begin
            result_q       <= alu_result;
            result_valid_q <= 1'b1;
            state_q        <= SHOW;
          end
        end
        SHOW: begin
          if (set_p_d) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign operand_a    = operand_a_q;
  assign operand_b    = operand_b_q;
  assign op_code      = op_code_q;
  assign alu_start    = alu_start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign state        = state_q;
  assign digit_cnt    = digit_cnt_q;
  assign key_err      = key_err_q;
  assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed self-checking bench for calc_seq_ctrl (MAX_DIGITS = 4).
module tb_calc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set = 1'b0;
  logic        append = 1'b0;
  logic [9:0]  key = 10'd0;
  logic        add = 1'b0, sub = 1'b0, mul = 1'b0, div = 1'b0;
  logic        alu_done = 1'b0;
  logic [27:0] alu_result = 28'd0;
  logic [13:0] operand_a, operand_b;
  logic [1:0]  op_code;
  logic        alu_start;
  logic [27:0] result;
  logic        result_valid;
  logic [2:0]  state;
  logic [2:0]  digit_cnt;
  logic        key_err;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  calc_seq_ctrl #(.MAX_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .set(set), .append(append), .key(key),
    .add(add), .sub(sub), .mul(mul), .div(div),
    .alu_done(alu_done), .alu_result(alu_result),
    .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
    .alu_start(alu_start), .result(result), .result_valid(result_valid),
    .state(state), .digit_cnt(digit_cnt), .key_err(key_err), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press_set();
    @(negedge clk); set = 1'b1;
    @(negedge clk); set = 1'b0;
  endtask

  task automatic press_append(input logic [9:0] k);
    @(negedge clk); append = 1'b1; key = k;
    @(negedge clk); append = 1'b0; key = 10'd0;
  endtask

  task automatic press_op(input logic a, input logic s, input logic m, input logic d);
    @(negedge clk); add = a; sub = s; mul = m; div = d; set = 1'b1;
    @(negedge clk); add = 1'b0; sub = 1'b0; mul = 1'b0; div = 1'b0; set = 1'b0;
  endtask

  task automatic pulse_done(input logic [27:0] r);
    @(negedge clk); alu_done = 1'b1; alu_result = r;
    @(negedge clk); alu_done = 1'b0; alu_result = 28'd0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_opa", 32'(operand_a), 32'd0);
    check("rst_start", 32'(alu_start), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    rst = 1'b0;

    // Operand A = 23
    press_set();
    check("idle_to_a", 32'(state), 32'd1);
    press_append(10'h004);
    check("a_digit1", 32'(operand_a), 32'd2);
    check("a_cnt1", 32'(digit_cnt), 32'd1);
    press_append(10'h008);
    check("a_23", 32'(operand_a), 32'd23);
    check("a_cnt2", 32'(digit_cnt), 32'd2);
    press_set();
    check("a_to_op", 32'(state), 32'd2);
    check("op_cnt_clr", 32'(digit_cnt), 32'd0);

    // Operator errors
    press_op(1'b0, 1'b0, 1'b0, 1'b0);
    check("op_none_err", 32'(key_err), 32'd1);
    check("op_none_stay", 32'(state), 32'd2);
    press_op(1'b1, 1'b1, 1'b0, 1'b0);
    check("op_multi_err", 32'(key_err), 32'd1);
    check("op_multi_stay", 32'(state), 32'd2);

    // add, operand B = 23, ALU returns 46
    press_op(1'b1, 1'b0, 1'b0, 1'b0);
    check("op_to_b", 32'(state), 32'd3);
    check("op_add", 32'(op_code), 32'd0);
    press_append(10'h004);
    press_append(10'h008);
    check("b_23", 32'(operand_b), 32'd23);
    press_set();
    check("calc_state", 32'(state), 32'd4);
    check("start_hi", 32'(alu_start), 32'd1);
    @(negedge clk);
    check("start_pulse", 32'(alu_start), 32'd0);
    check("calc_wait", 32'(state), 32'd4);
    pulse_done(28'd46);
    check("res_46", 32'(result), 32'd46);
    check("res_valid", 32'(result_valid), 32'd1);
    check("show_state", 32'(state), 32'd5);

    // alu_done outside CALC ignored
    pulse_done(28'd99);
    check("done_ignored", 32'(result), 32'd46);
    check("show_hold", 32'(state), 32'd5);

    // New calculation: digit limits and bad keys
    press_set();
    check("show_to_idle", 32'(state), 32'd0);
    press_set();
    check("valid_clr", 32'(result_valid), 32'd0);
    check("opa_clr", 32'(operand_a), 32'd0);
    press_append(10'h002);
    press_append(10'h003);
    check("multihot_err", 32'(key_err), 32'd1);
    check("multihot_keep", 32'(operand_a), 32'd1);
    check("multihot_cnt", 32'(digit_cnt), 32'd1);
    @(negedge clk);
    check("err_one_cycle", 32'(key_err), 32'd0);
    press_append(10'h000);
    check("zero_key_err", 32'(key_err), 32'd1);
    press_append(10'h002);
    press_append(10'h002);
    press_append(10'h002);
    check("a_1111", 32'(operand_a), 32'd1111);
    check("a_cnt4", 32'(digit_cnt), 32'd4);
    check("no_err_4th", 32'(key_err), 32'd0);
    press_append(10'h002);
    check("fifth_err", 32'(key_err), 32'd1);
    check("fifth_nowrap", 32'(operand_a), 32'd1111);

    // Division by zero
    press_set();
    press_op(1'b0, 1'b0, 1'b0, 1'b1);
    check("op_div", 32'(op_code), 32'd3);
    press_set();
    check("dz_calc", 32'(state), 32'd4);
    check("dz_flag", 32'(div_zero), 32'd1);
    check("dz_nostart", 32'(alu_start), 32'd0);
    check("dz_result", 32'(result), 32'd0);
    @(negedge clk);
    check("dz_show", 32'(state), 32'd5);
    check("dz_nostart2", 32'(alu_start), 32'd0);

    // set and append together: set wins
    press_set();
    press_set();
    check("dz_clr", 32'(div_zero), 32'd0);
    @(negedge clk); set = 1'b1; append = 1'b1; key = 10'h020;
    @(negedge clk); set = 1'b0; append = 1'b0; key = 10'd0;
    check("both_state", 32'(state), 32'd2);
    check("both_opa", 32'(operand_a), 32'd0);
    check("both_noerr", 32'(key_err), 32'd0);

    // Reset while in CALC, later alu_done ignored
    press_op(1'b0, 1'b0, 1'b1, 1'b0);
    check("op_mul", 32'(op_code), 32'd2);
    press_append(10'h008);
    check("b_3", 32'(operand_b), 32'd3);
    press_set();
    check("calc2_start", 32'(alu_start), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_start", 32'(alu_start), 32'd0);
    check("arst_opb", 32'(operand_b), 32'd0);
    check("arst_opcode", 32'(op_code), 32'd0);
    @(negedge clk); rst = 1'b0;
    pulse_done(28'd77);
    check("post_rst_res", 32'(result), 32'd0);
    check("post_rst_valid", 32'(result_valid), 32'd0);
    check("post_rst_state", 32'(state), 32'd0);

`ifdef CALC_SEQ_EDGE_EN
    // Held append adds a single digit
    press_set();
    @(negedge clk); append = 1'b1; key = 10'h002;
    repeat (10) @(negedge clk);
    append = 1'b0; key = 10'd0;
    @(negedge clk);
    check("held_opa", 32'(operand_a), 32'd1);
    check("held_cnt", 32'(digit_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 Parameter MAX_DIGITS, default 4, SHALL set the maximum decimal digits per operand (legal 1..4).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 set  input  1  SHALL be the advance/confirm button, synchronous to clk.
REQ-005 append  input  1  SHALL be the push-digit button, synchronous to clk.
REQ-006 key  input  10  SHALL be the one-hot digit select; bit n = digit n.
REQ-007 add, sub, mul, div  input  1 each  SHALL be the operator selects.
REQ-008 alu_done  input  1  SHALL be a one-cycle ALU completion pulse.
REQ-009 alu_result  input  28  SHALL be the signed ALU result, valid with alu_done.
REQ-010 operand_a, operand_b  output  14 each  SHALL be the accumulated unsigned operands.
REQ-011 op_code  output  2  SHALL be the latched operator: 0 add, 1 sub, 2 mul, 3 div.
REQ-012 alu_start  output  1  SHALL be a one-cycle ALU launch pulse.
REQ-013 result  output  28  SHALL be the latched result; result_valid  output  1  SHALL flag it.
REQ-014 state  output  3  SHALL expose the FSM state; digit_cnt  output  3  SHALL expose digits entered in the current operand.
REQ-015 key_err, div_zero  output  1 each  SHALL flag rejected input and division by zero.

Function
REQ-016 The FSM SHALL use states IDLE=0, ENTER_A=1, ENTER_OP=2, ENTER_B=3, CALC=4, SHOW=5.
REQ-017 IDLE: set -> ENTER_A; operands, digit_cnt, result_valid, key_err, div_zero cleared.
REQ-018 ENTER_A/ENTER_B: append with exactly one key bit high and digit_cnt<MAX_DIGITS SHALL update operand = operand*10 + digit and increment digit_cnt, both visible the next cycle.
REQ-019 An append with key zero or multi-hot SHALL leave the operand unchanged and pulse key_err for one cycle.
REQ-020 An append at digit_cnt==MAX_DIGITS SHALL be ignored and pulse key_err; the operand SHALL NOT wrap.
REQ-021 set in ENTER_A -> ENTER_OP, in ENTER_B -> CALC; digit_cnt SHALL clear; a zero-digit operand SHALL equal 0.
REQ-022 ENTER_OP: set with exactly one operator high SHALL latch op_code and go to ENTER_B; otherwise it SHALL stay in ENTER_OP and pulse key_err.
REQ-023 On entry to CALC, alu_start SHALL pulse exactly one cycle unless op_code==3 and operand_b==0, in which case div_zero SHALL set, result SHALL be 0, and the FSM SHALL go to SHOW the next cycle without alu_start.
REQ-024 CALC SHALL wait for alu_done indefinitely; on alu_done, result<=alu_result, result_valid<=1, next state SHOW.
REQ-025 alu_done outside CALC SHALL be ignored.
REQ-026 SHOW: set -> IDLE; result and result_valid hold until then.
REQ-027 set and append in the same cycle: set SHALL win and append SHALL be dropped.
REQ-028 set and append SHALL each act once per press (see REQ-033).

Reset
REQ-029 On rst high, all outputs and state SHALL go to 0 (IDLE) asynchronously, including alu_start.
REQ-030 Reset mid-operation, including in CALC, SHALL abandon the calculation; a later alu_done SHALL be ignored.
REQ-031 After rst deasserts, the first rising clk edge SHALL evaluate inputs normally.

Configuration
REQ-032 Macro CALC_SEQ_EDGE_EN SHALL select input qualification.
REQ-033 With CALC_SEQ_EDGE_EN defined, set and append SHALL be rising-edge detected internally via a one-cycle registered copy, so a held button acts once; without it, each cycle set or append is high SHALL count as one press.

Verification
REQ-034 rst, set, append key=0x004, append key=0x008 -> operand_a=23, digit_cnt=2; set -> state=2.
REQ-035 In ENTER_OP, add=1, set; enter 23, set -> alu_start single pulse, op_code=0; alu_done with alu_result=46 -> result=46, result_valid=1, state=5.
REQ-036 div selected, operand_b=0, set -> div_zero=1, no alu_start, state=5 next cycle.
REQ-037 Five appends of key=0x002 with MAX_DIGITS=4 -> operand=1111, fifth append pulses key_err; key=0x003 append -> key_err, operand unchanged.
REQ-038 rst asserted in CALC before alu_done -> all outputs 0, state=0; following alu_done -> no change. With CALC_SEQ_EDGE_EN, append held 10 cycles -> one digit added.
